sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of switch channels (2..16).
REQ-002 SHALL have parameter DEB_LOG2, default 16, giving the debounce counter width; the filter window is 2^DEB_LOG2 cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sw, input, WIDTH bits: raw asynchronous switch levels, with sw[0] corresponding to sw1.
REQ-006 SHALL have port sw_db, output, WIDTH bits: debounced stable levels, registered.
REQ-007 SHALL have port sw_rise, output, WIDTH bits: one-cycle pulse per channel on a debounced 0->1 transition.
REQ-008 SHALL have port sw_fall, output, WIDTH bits: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-009 SHALL have port evt_valid, output, 1 bit: an event is presented.
REQ-010 SHALL have port evt_idx, output, clog2(WIDTH) bits: channel index of the presented event.
REQ-011 SHALL have port evt_dir, output, 1 bit: direction of the presented event, 1 = rise, 0 = fall.
REQ-012 SHALL have port evt_ready, input, 1 bit: the consumer accepts the presented event.
REQ-013 SHALL have port evt_ovf, output, 1 bit: sticky flag, set when an event was overwritten before being queued.

Function
REQ-014 SHALL pass each sw bit through a 2-flop synchronizer; only the second-stage output (sync) feeds the filter.
REQ-015 SHALL keep one DEB_LOG2-bit counter per channel, updated each cycle as follows:
- sync==sw_db: counter <= 0.
- Otherwise, counter < 2^DEB_LOG2-1: counter <= counter+1.
- Otherwise, counter == max: sw_db <= sync and counter <= 0.
REQ-016 SHALL update sw_db 2^DEB_LOG2+2 rising edges after a clean input change, counting the first edge that samples the new level as edge 1.
REQ-017 SHALL leave sw_db unchanged for any sync mismatch lasting fewer than 2^DEB_LOG2 consecutive cycles; the counter restarts from 0 when the mismatch ends.
REQ-018 SHALL assert sw_rise[i] or sw_fall[i] on the same edge that sw_db[i] changes, for exactly one cycle; sw_rise[i] and sw_fall[i] are never both high.
REQ-019 SHALL keep a pending bit and a pending direction per channel; both are set on the edge that asserts sw_rise[i] or sw_fall[i].
REQ-020 SHALL load the output stage whenever it is empty (evt_valid=0) or being accepted (evt_valid && evt_ready) and any pending bit is set:
- Take the lowest-index pending channel into evt_idx and evt_dir.
- Clear that channel's pending bit.
- Set evt_valid.
REQ-021 SHALL clear evt_valid when an event is accepted and no pending bit is set.
REQ-022 SHALL hold evt_idx and evt_dir stable while evt_valid=1 and evt_ready=0.
REQ-023 SHALL present a new event no earlier than the edge after its pending bit is set (1-cycle latency into an empty stage).
REQ-024 SHALL overwrite the pending direction and set evt_ovf when a new debounced edge arrives on a channel whose pending bit is set and not being loaded on that cycle; the pending bit stays set.
REQ-025 SHALL, when a channel is loaded into the output stage and gets a new debounced edge on the same cycle, leave the new edge pending without setting evt_ovf.
REQ-026 SHALL accept simultaneous edges on several channels without loss; they are presented in ascending index order on successive accepts.
REQ-027 SHALL keep evt_ovf set until rst.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all of the following:
- synchronizer flops, counters and pending bits;
- sw_db, sw_rise, sw_fall;
- evt_valid, evt_idx, evt_dir, evt_ovf.
REQ-029 SHALL abandon any in-progress debounce count or unaccepted event on reset mid-operation.
REQ-030 SHALL, after reset is released with a switch held high, treat that switch as a normal 0->1 change: sw_rise pulses at edge 2^DEB_LOG2+2 and a rise event is queued.

Verification (DEB_LOG2=4, WIDTH=8)
REQ-031 Clean step: sw=0x01 from edge 1 -> sw_db=0x01 and sw_rise=0x01 for 1 cycle at edge 18; evt_valid=1, evt_idx=0, evt_dir=1 at edge 19.
REQ-032 Glitch: sw[3] high for 15 cycles, then low -> sw_db, sw_rise and sw_fall stay 0; no event.
REQ-033 Simultaneous edges with evt_ready=0: sw 0x00->0x86 -> sw_db=0x86 on one edge; evt_idx=1 is held while evt_ready=0; raising evt_ready yields idx 1, 2, 7, each with dir=1, on consecutive cycles, then evt_valid=0.
REQ-034 Overflow: evt_ready=0, channel 5 rises, debounces, falls and debounces while channel 0's event occupies the output stage -> evt_ovf=1; the later accept presents idx 5, dir=0.
REQ-035 Reset mid-count: rst pulsed at counter=10 on channel 2 with sw[2] still high -> all outputs 0; sw_db[2] rises 18 edges after rst deasserts.

Source files
------------

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: 2-flop synchronizer, per-channel saturating
// filter counter, edge pulses and a single-entry event output stage.
module sw_debounce #(
   parameter  int WIDTH    = 8,
   parameter  int DEB_LOG2 = 16,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             evt_valid,
   output logic [IDX_W-1:0] evt_idx,
   output logic             evt_dir,
   input  logic             evt_ready,
   output logic             evt_ovf
);

   localparam logic [DEB_LOG2-1:0] CNT_MAX = {DEB_LOG2{1'b1}};
   localparam logic [DEB_LOG2-1:0] CNT_ONE = {{(DEB_LOG2-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    sync1_q, sync1_d;
   logic [WIDTH-1:0]    sync2_q, sync2_d;
   logic [DEB_LOG2-1:0] cnt_q [WIDTH];
   logic [DEB_LOG2-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0]    db_q, db_d;
   logic [WIDTH-1:0]    rise_q, rise_d;
   logic [WIDTH-1:0]    fall_q, fall_d;
   logic [WIDTH-1:0]    pend_q, pend_d;
   logic [WIDTH-1:0]    pdir_q, pdir_d;
   logic                valid_q, valid_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                dir_q, dir_d;
   logic                ovf_q, ovf_d;
   logic [IDX_W-1:0]    sel_idx_s;
   logic                load_s;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pend_q  <= '0;
         pdir_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pend_q  <= pend_d;
         pdir_q  <= pdir_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         ovf_q   <= ovf_d;
      end
   end

   // Filter, edge detection, pending tracking and output-stage next state
   always_comb begin
      sync1_d   = sw;
      sync2_d   = sync1_q;
      db_d      = db_q;
      rise_d    = '0;
      fall_d    = '0;
      pend_d    = pend_q;
      pdir_d    = pdir_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      dir_d     = dir_q;
      ovf_d     = ovf_q;
      sel_idx_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      // Scan downward so the lowest pending index wins
      for (int i = WIDTH - 1; i >= 0; i--) begin
         sel_idx_s = pend_q[i] ? IDX_W'(i) : sel_idx_s;
      end
      load_s = (~valid_q | evt_ready) & (|pend_q);

      if (load_s) begin
         valid_d           = 1'b1;
         idx_d             = sel_idx_s;
         dir_d             = pdir_q[sel_idx_s];
         pend_d[sel_idx_s] = 1'b0;
      end else if (valid_q && evt_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      // New edges are applied after the load so a same-cycle edge stays pending
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else begin
            cnt_d[i]  = '0;
            db_d[i]   = sync2_q[i];
            rise_d[i] = sync2_q[i];
            fall_d[i] = ~sync2_q[i];
            pend_d[i] = 1'b1;
            pdir_d[i] = sync2_q[i];
            if (pend_q[i] && !(load_s && (sel_idx_s == IDX_W'(i)))) begin
               ovf_d = 1'b1;
            end else begin
               ovf_d = ovf_d;
            end
         end
      end
   end

   assign sw_db     = db_q;
   assign sw_rise   = rise_q;
   assign sw_fall   = fall_q;
   assign evt_valid = valid_q;
   assign evt_idx   = idx_q;
   assign evt_dir   = dir_q;
   assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=8, DEB_LOG2=4) with an event scoreboard.
module tb_sw_debounce;

   typedef struct packed {
      logic [2:0] idx;
      logic       dir;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] sw_db;
   logic [7:0] sw_rise;
   logic [7:0] sw_fall;
   logic       evt_valid;
   logic [2:0] evt_idx;
   logic       evt_dir;
   logic       evt_ready;
   logic       evt_ovf;

   int  total = 0;
   int  bad   = 0;
   ev_t exp_q[$];

   sw_debounce #(.WIDTH(8), .DEB_LOG2(4)) dut (
      .clk(clk), .rst(rst), .sw(sw), .sw_db(sw_db), .sw_rise(sw_rise),
      .sw_fall(sw_fall), .evt_valid(evt_valid), .evt_idx(evt_idx),
      .evt_dir(evt_dir), .evt_ready(evt_ready), .evt_ovf(evt_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted event is matched against the queue
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL evt_unexpected: got idx=%0d dir=%0d expected none", evt_idx, evt_dir);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (evt_idx !== e.idx || evt_dir !== e.dir) begin
               bad++;
               $display("FAIL evt_match: got idx=%0d dir=%0d expected idx=%0d dir=%0d",
                        evt_idx, evt_dir, e.idx, e.dir);
            end
         end
      end
   end

   initial begin
      logic glitch_ok;
      rst = 1'b1; sw = 8'h00; evt_ready = 1'b0;
      step(3);
      chk("reset_db", {24'd0, sw_db}, 32'h0);
      chk("reset_valid_ovf", {30'd0, evt_valid, evt_ovf}, 32'h0);
      rst = 1'b0;
      step(2);

      // Clean step on channel 0
      sw = 8'h01;
      step(17);
      chk("step_db_e17", {24'd0, sw_db}, 32'h00);
      step(1);
      chk("step_db_e18", {24'd0, sw_db}, 32'h01);
      chk("step_rise_e18", {24'd0, sw_rise}, 32'h01);
      chk("step_valid_e18", {31'd0, evt_valid}, 32'h0);
      step(1);
      chk("step_rise_e19", {24'd0, sw_rise}, 32'h00);
      chk("step_evt_e19", {28'd0, evt_valid, evt_idx}, {28'd0, 1'b1, 3'd0});
      chk("step_dir_e19", {31'd0, evt_dir}, 32'h1);
      exp_q.push_back('{idx: 3'd0, dir: 1'b1});
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      chk("step_valid_after", {31'd0, evt_valid}, 32'h0);

      // 15-cycle glitch on channel 3 must be filtered out
      sw = 8'h09;
      step(15);
      sw = 8'h01;
      glitch_ok = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (sw_db !== 8'h01 || sw_rise !== 8'h00 || sw_fall !== 8'h00 || evt_valid !== 1'b0)
            glitch_ok = 1'b0;
      end
      chk("glitch_filtered", {31'd0, glitch_ok}, 32'h1);

      // Simultaneous edges, presented in index order
      rst = 1'b1; sw = 8'h00;
      step(2);
      rst = 1'b0;
      sw = 8'h86;
      step(17);
      chk("multi_db_e17", {24'd0, sw_db}, 32'h00);
      step(1);
      chk("multi_db_e18", {24'd0, sw_db}, 32'h86);
      chk("multi_rise_e18", {24'd0, sw_rise}, 32'h86);
      step(1);
      chk("multi_first", {28'd0, evt_valid, evt_idx}, {28'd0, 1'b1, 3'd1});
      step(3);
      chk("multi_hold", {27'd0, evt_valid, evt_idx, evt_dir}, {27'd0, 1'b1, 3'd1, 1'b1});
      exp_q.push_back('{idx: 3'd1, dir: 1'b1});
      exp_q.push_back('{idx: 3'd2, dir: 1'b1});
      exp_q.push_back('{idx: 3'd7, dir: 1'b1});
      evt_ready = 1'b1;
      step(3);
      evt_ready = 1'b0;
      chk("multi_drained", {31'd0, evt_valid}, 32'h0);

      // Overflow: channel 5 rises and falls while channel 0 blocks the stage
      sw = 8'h87;
      step(19);
      chk("ovf_blocker", {28'd0, evt_valid, evt_idx}, {28'd0, 1'b1, 3'd0});
      exp_q.push_back('{idx: 3'd0, dir: 1'b1});
      sw = 8'hA7;
      step(18);
      chk("ovf_ch5_rise", {24'd0, sw_rise}, 32'h20);
      chk("ovf_not_yet", {31'd0, evt_ovf}, 32'h0);
      sw = 8'h87;
      step(18);
      chk("ovf_ch5_fall", {24'd0, sw_fall}, 32'h20);
      step(1);
      chk("ovf_set", {31'd0, evt_ovf}, 32'h1);
      exp_q.push_back('{idx: 3'd5, dir: 1'b0});
      evt_ready = 1'b1;
      step(2);
      evt_ready = 1'b0;
      chk("ovf_drained", {31'd0, evt_valid}, 32'h0);
      chk("ovf_sticky", {31'd0, evt_ovf}, 32'h1);

      // Reset mid-count with pending and presented events abandoned
      sw = 8'h00;
      step(19);
      chk("pre_rst_valid", {31'd0, evt_valid}, 32'h1);
      sw = 8'h04;
      step(12);
      rst = 1'b1;
      step(1);
      chk("rst_outs", {8'd0, sw_db, sw_rise, sw_fall},  32'h0);
      chk("rst_evt", {26'd0, evt_valid, evt_idx, evt_dir, evt_ovf}, 32'h0);
      rst = 1'b0;
      step(17);
      chk("rst_db_e17", {24'd0, sw_db}, 32'h00);
      step(1);
      chk("rst_db_e18", {24'd0, sw_db}, 32'h04);
      chk("rst_rise_e18", {24'd0, sw_rise}, 32'h04);
      step(1);
      exp_q.push_back('{idx: 3'd2, dir: 1'b1});
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      chk("rst_drained", {31'd0, evt_valid}, 32'h0);

      step(2);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
